// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs decoded MIPS-subset instruction fields into 32-bit words and
// writes them sequentially into instruction memory. Define LOADER_READBACK_EN for write-then-verify.

module instr_mem_loader #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  start_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_kind,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [15:0] in_imm,
   input  logic [25:0] in_jaddr,
   input  logic        in_last,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic [8:0]  word_count,
   output logic        err_illegal,
   output logic        full
`ifdef LOADER_READBACK_EN
   ,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   output logic        err_verify
`endif
);

   localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

   localparam logic [3:0] KIND_ADD  = 4'd0;
   localparam logic [3:0] KIND_SUB  = 4'd1;
   localparam logic [3:0] KIND_AND  = 4'd2;
   localparam logic [3:0] KIND_OR   = 4'd3;
   localparam logic [3:0] KIND_ADDI = 4'd4;
   localparam logic [3:0] KIND_LW   = 4'd5;
   localparam logic [3:0] KIND_SW   = 4'd6;
   localparam logic [3:0] KIND_BEQ  = 4'd7;
   localparam logic [3:0] KIND_J    = 4'd8;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DONE,
      S_RD,
      S_CMP
   } state_t;

   state_t      state_q;
   logic [7:0]  ptr_q;
   logic        mem_we_q;
   logic [7:0]  mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic        in_ready_q;
   logic        busy_q;
   logic        done_q;
   logic [8:0]  word_count_q;
   logic        err_illegal_q;
   logic        full_q;
`ifdef LOADER_READBACK_EN
   logic        term_q;
   logic        mem_re_q;
   logic        err_verify_q;
`endif

   logic [31:0] packedWord;
   logic        kindLegal;
   logic        handshake;
   logic        atLastAddr;

   assign handshake  = in_valid & in_ready_q;
   assign atLastAddr = (ptr_q == LAST_ADDR);

   // Only the fields belonging to the selected format reach the word; the rest stay masked.
   always_comb begin
      packedWord = '0;
      kindLegal  = 1'b1;
      case (in_kind)
         KIND_ADD:  packedWord = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FUNCT_ADD};
         KIND_SUB:  packedWord = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FUNCT_SUB};
         KIND_AND:  packedWord = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FUNCT_AND};
         KIND_OR:   packedWord = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FUNCT_OR};
         KIND_ADDI: packedWord = {OP_ADDI, in_rs, in_rt, in_imm};
         KIND_LW:   packedWord = {OP_LW, in_rs, in_rt, in_imm};
         KIND_SW:   packedWord = {OP_SW, in_rs, in_rt, in_imm};
         KIND_BEQ:  packedWord = {OP_BEQ, in_rs, in_rt, in_imm};
         KIND_J:    packedWord = {OP_J, in_jaddr};
         default:   kindLegal  = 1'b0;
      endcase
   end

   // Session FSM with every output registered. The pointer saturates at the last
   // address because a write there always ends the session.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         in_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         word_count_q  <= '0;
         err_illegal_q <= 1'b0;
         full_q        <= 1'b0;
`ifdef LOADER_READBACK_EN
         term_q        <= 1'b0;
         mem_re_q      <= 1'b0;
         err_verify_q  <= 1'b0;
`endif
      end else begin
         mem_we_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q       <= S_LOAD;
                  ptr_q         <= start_addr;
                  word_count_q  <= '0;
                  err_illegal_q <= 1'b0;
                  full_q        <= 1'b0;
                  busy_q        <= 1'b1;
                  in_ready_q    <= 1'b1;
`ifdef LOADER_READBACK_EN
                  term_q        <= 1'b0;
                  err_verify_q  <= 1'b0;
`endif
               end
            end
            S_LOAD, S_CMP: begin
`ifdef LOADER_READBACK_EN
               if (state_q == S_LOAD && mem_we_q) begin
                  state_q  <= S_RD;
                  mem_re_q <= 1'b1;
               end
               if (state_q == S_CMP) begin
                  if (mem_rdata != mem_wdata_q) begin
                     err_verify_q <= 1'b1;
                  end
                  if (term_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_LOAD;
                  end
               end
`endif
               if (handshake) begin
                  if (kindLegal) begin
                     mem_we_q     <= 1'b1;
                     mem_addr_q   <= ptr_q;
                     mem_wdata_q  <= packedWord;
                     word_count_q <= word_count_q + 9'd1;
                     if (!atLastAddr) begin
                        ptr_q <= ptr_q + 8'd1;
                     end else if (!in_last) begin
                        full_q <= 1'b1;
                     end
`ifdef LOADER_READBACK_EN
                     in_ready_q <= 1'b0;
                     term_q     <= in_last | atLastAddr;
`else
                     if (in_last || atLastAddr) begin
                        state_q    <= S_DONE;
                        in_ready_q <= 1'b0;
                        done_q     <= 1'b1;
                     end
`endif
                  end else begin
                     err_illegal_q <= 1'b1;
                     if (in_last) begin
                        state_q    <= S_DONE;
                        in_ready_q <= 1'b0;
                        done_q     <= 1'b1;
                     end
                  end
               end
            end
`ifdef LOADER_READBACK_EN
            // Memory samples the read address this cycle; data is compared in CMP,
            // which may already accept the next bundle.
            S_RD: begin
               mem_re_q   <= 1'b0;
               state_q    <= S_CMP;
               in_ready_q <= ~term_q;
            end
`endif
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign word_count  = word_count_q;
   assign err_illegal = err_illegal_q;
   assign full        = full_q;
`ifdef LOADER_READBACK_EN
   assign mem_re      = mem_re_q;
   assign err_verify  = err_verify_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: directed scenarios plus randomized sessions checked
// against a list-based reference model. Readback checks build with LOADER_READBACK_EN.

module tb_instr_mem_loader;

   typedef struct {
      logic [3:0]  kind;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] jaddr;
      logic        last;
   } bundle_t;

`ifdef LOADER_READBACK_EN
   localparam int SPACING = 3;
`else
   localparam int SPACING = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  start_addr = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_kind = '0;
   logic [4:0]  in_rs = '0;
   logic [4:0]  in_rt = '0;
   logic [4:0]  in_rd = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_jaddr = '0;
   logic        in_last = 1'b0;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic [8:0]  word_count;
   logic        err_illegal;
   logic        full;
`ifdef LOADER_READBACK_EN
   logic        mem_re;
   logic [31:0] mem_rdata = '0;
   logic        err_verify;
   logic [31:0] memModel [256];
   logic        verifyAtDone;
`endif

   int total = 0;
   int bad = 0;
   int cycle = 0;

   bundle_t     stim[$];
   logic [7:0]  gotAddr[$];
   logic [31:0] gotData[$];
   int          gotCycle[$];
   int          hsCycle[$];
   int          doneCount;
   int          wcAtDone;
   int          acceptedCount;
   logic        readyAtDone, illAtDone, fullAtDone, busyAfterDone, busyAtStart, readyAtStart;
   bit          timedOut;

   logic [7:0]  expAddr[$];
   logic [31:0] expData[$];
   int          expAcc, expWc;
   logic        expIll, expFull;

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   instr_mem_loader #(.DEPTH(256)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_jaddr(in_jaddr), .in_last(in_last), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
      .word_count(word_count), .err_illegal(err_illegal), .full(full)
`ifdef LOADER_READBACK_EN
      , .mem_re(mem_re), .mem_rdata(mem_rdata), .err_verify(err_verify)
`endif
   );

`ifdef LOADER_READBACK_EN
   // Faulty memory: bit 0 of the word stored at address 0x02 is flipped.
   always @(posedge clk) begin
      if (mem_we) memModel[mem_addr] <= (mem_addr == 8'h02) ? (mem_wdata ^ 32'h1) : mem_wdata;
      if (mem_re) mem_rdata <= memModel[mem_addr];
   end
`endif

   function automatic bundle_t mk(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [15:0] imm, input logic last);
      bundle_t b;
      b.kind = k; b.rs = rs; b.rt = rt; b.rd = rd; b.imm = imm;
      b.jaddr = 26'($urandom);
      b.last = last;
      return b;
   endfunction

   function automatic logic [31:0] packRef(input bundle_t b);
      case (b.kind)
         4'd0: return {6'h00, b.rs, b.rt, b.rd, 5'd0, 6'h20};
         4'd1: return {6'h00, b.rs, b.rt, b.rd, 5'd0, 6'h22};
         4'd2: return {6'h00, b.rs, b.rt, b.rd, 5'd0, 6'h24};
         4'd3: return {6'h00, b.rs, b.rt, b.rd, 5'd0, 6'h25};
         4'd4: return {6'h08, b.rs, b.rt, b.imm};
         4'd5: return {6'h23, b.rs, b.rt, b.imm};
         4'd6: return {6'h2b, b.rs, b.rt, b.imm};
         4'd7: return {6'h04, b.rs, b.rt, b.imm};
         4'd8: return {6'h02, b.jaddr};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [54:0] outVec();
      return {mem_we, mem_addr, mem_wdata, in_ready, busy, done, word_count, err_illegal, full};
   endfunction

   // Reference: walk the bundle list and list the writes a session should produce.
   task automatic modelSession(input logic [7:0] sa);
      logic [7:0] ptr = sa;
      expAddr.delete(); expData.delete();
      expAcc = 0; expWc = 0; expIll = 1'b0; expFull = 1'b0;
      foreach (stim[i]) begin
         expAcc++;
         if (stim[i].kind > 4'd8) begin
            expIll = 1'b1;
            if (stim[i].last) break;
         end else begin
            expAddr.push_back(ptr);
            expData.push_back(packRef(stim[i]));
            expWc++;
            if (stim[i].last) break;
            if (ptr == 8'hFF) begin
               expFull = 1'b1;
               break;
            end
            ptr++;
         end
      end
   endtask

   task automatic applyStimulus(input bundle_t b);
      in_kind = b.kind; in_rs = b.rs; in_rt = b.rt; in_rd = b.rd;
      in_imm = b.imm; in_jaddr = b.jaddr; in_last = b.last;
   endtask

   task automatic runSession(input logic [7:0] sa, input bit gaps, input bit pokeStart);
      int idx = 0;
      int cycles = 0;
      bit hs;
      bit doneFlag = 0;
      gotAddr.delete(); gotData.delete(); gotCycle.delete(); hsCycle.delete();
      doneCount = 0; wcAtDone = -1; timedOut = 0;
      readyAtDone = 1'bx; illAtDone = 1'bx; fullAtDone = 1'bx; busyAfterDone = 1'bx;
      @(posedge clk); #1;
      start = 1'b1; start_addr = sa; in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      busyAtStart = busy; readyAtStart = in_ready;
      while (1) begin
         if (doneFlag) begin
            busyAfterDone = busy;
            break;
         end
         if (cycles >= 400) begin
            timedOut = 1;
            break;
         end
         if (mem_we) begin
            gotAddr.push_back(mem_addr);
            gotData.push_back(mem_wdata);
            gotCycle.push_back(cycle);
         end
         if (done) begin
            doneCount++;
            doneFlag = 1;
            wcAtDone = int'(word_count);
            readyAtDone = in_ready; illAtDone = err_illegal; fullAtDone = full;
`ifdef LOADER_READBACK_EN
            verifyAtDone = err_verify;
`endif
         end
         start = pokeStart && busy && !done && ($urandom_range(3) == 0);
         start_addr = 8'($urandom);
         if (idx < stim.size() && (!gaps || $urandom_range(2) != 0)) begin
            applyStimulus(stim[idx]);
            in_valid = 1'b1;
         end else begin
            applyStimulus(mk(4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b1));
            in_valid = 1'b0;
         end
         hs = in_valid && in_ready;
         if (hs) hsCycle.push_back(cycle);
         @(posedge clk); #1;
         cycles++;
         if (hs) idx++;
      end
      in_valid = 1'b0; start = 1'b0;
      acceptedCount = idx;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (outVec() !== 55'd0) begin
         bad++; $display("[TB] FAIL reset_outputs: got %h expected 0", outVec());
      end
      rst = 1'b0;
      applyStimulus(mk(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0));
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         total++;
         if ({mem_we, in_ready, busy} !== 3'b000) begin
            bad++; $display("[TB] FAIL idle_ignores_valid: we/ready/busy=%b expected 000", {mem_we, in_ready, busy});
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_single_add();
      stim.delete();
      stim.push_back(mk(4'd0, 5'd1, 5'd2, 5'd3, 16'($urandom), 1'b1));
      runSession(8'h00, 0, 0);
      total++;
      if ({busyAtStart, readyAtStart} !== 2'b11) begin
         bad++; $display("[TB] FAIL start_latency: busy/ready=%b expected 11", {busyAtStart, readyAtStart});
      end
      total++;
      if (timedOut || gotData.size() != 1 || gotAddr[0] !== 8'h00 || gotData[0] !== 32'h00221820) begin
         bad++; $display("[TB] FAIL add_write: n=%0d addr=%h data=%h expected 1 write 00/00221820",
                         gotData.size(), gotAddr.size() ? gotAddr[0] : 8'hxx, gotData.size() ? gotData[0] : 32'hx);
      end
      total++;
      if (gotCycle.size() != 1 || hsCycle.size() != 1 || gotCycle[0] != hsCycle[0] + 1) begin
         bad++; $display("[TB] FAIL add_latency: write cycles=%0d handshakes=%0d, write not one cycle after handshake",
                         gotCycle.size(), hsCycle.size());
      end
      total++;
      if (doneCount != 1 || wcAtDone != 1 || busyAfterDone !== 1'b0) begin
         bad++; $display("[TB] FAIL add_done: done=%0d wc=%0d busyAfter=%b expected 1/1/0", doneCount, wcAtDone, busyAfterDone);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] want[5] = '{32'h00221822, 32'h20050007, 32'h8C240010, 32'h1022FFFF, 32'h08000010};
      bundle_t j;
      stim.delete();
      stim.push_back(mk(4'd1, 5'd1, 5'd2, 5'd3, 16'($urandom), 1'b0));
      stim.push_back(mk(4'd4, 5'd0, 5'd5, 5'($urandom), 16'h0007, 1'b0));
      stim.push_back(mk(4'd5, 5'd1, 5'd4, 5'($urandom), 16'h0010, 1'b0));
      stim.push_back(mk(4'd7, 5'd1, 5'd2, 5'($urandom), 16'hFFFF, 1'b0));
      j = mk(4'd8, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b1);
      j.jaddr = 26'h0000010;
      stim.push_back(j);
      runSession(8'h20, 0, 0);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (gotData.size() <= i || gotAddr[i] !== 8'(32'h20 + i) || gotData[i] !== want[i]) begin
            bad++; $display("[TB] FAIL b2b_word%0d: n=%0d addr=%h data=%h expected %h/%h", i, gotData.size(),
                            gotAddr.size() > i ? gotAddr[i] : 8'hxx, gotData.size() > i ? gotData[i] : 32'hx,
                            8'(32'h20 + i), want[i]);
         end
      end
      for (int i = 1; i < 5; i++) begin
         total++;
         if (gotCycle.size() <= i || gotCycle[i] - gotCycle[i-1] != SPACING) begin
            bad++; $display("[TB] FAIL b2b_spacing%0d: write spacing wrong, expected %0d cycles", i, SPACING);
         end
      end
      total++;
      if (timedOut || doneCount != 1 || wcAtDone != 5) begin
         bad++; $display("[TB] FAIL b2b_done: done=%0d wc=%0d expected 1/5", doneCount, wcAtDone);
      end
   endtask

   task automatic test_illegal();
      stim.delete();
      stim.push_back(mk(4'd0, 5'd1, 5'd2, 5'd3, 16'($urandom), 1'b0));
      stim.push_back(mk(4'd12, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b0));
      stim.push_back(mk(4'd0, 5'd4, 5'd5, 5'd6, 16'($urandom), 1'b1));
      runSession(8'h30, 0, 0);
      total++;
      if (gotData.size() != 2 || gotAddr[0] !== 8'h30 || gotAddr[1] !== 8'h31 ||
          gotData[0] !== 32'h00221820 || gotData[1] !== 32'h00853020) begin
         bad++; $display("[TB] FAIL illegal_writes: n=%0d expected 2 writes 30:00221820 31:00853020", gotData.size());
      end
      total++;
      if (timedOut || illAtDone !== 1'b1 || wcAtDone != 2) begin
         bad++; $display("[TB] FAIL illegal_flags: err_illegal=%b wc=%0d expected 1/2", illAtDone, wcAtDone);
      end
   endtask

   task automatic test_full();
      stim.delete();
      for (int i = 0; i < 3; i++) stim.push_back(mk(4'd0, 5'(i), 5'd2, 5'd3, 16'($urandom), 1'b0));
      runSession(8'hFE, 0, 0);
      total++;
      if (gotAddr.size() != 2 || gotAddr[0] !== 8'hFE || gotAddr[1] !== 8'hFF) begin
         bad++; $display("[TB] FAIL full_writes: n=%0d expected writes at FE,FF", gotAddr.size());
      end
      total++;
      if (timedOut || doneCount != 1 || fullAtDone !== 1'b1 || wcAtDone != 2) begin
         bad++; $display("[TB] FAIL full_flags: done=%0d full=%b wc=%0d expected 1/1/2", doneCount, fullAtDone, wcAtDone);
      end
      total++;
      if (acceptedCount != 2 || readyAtDone !== 1'b0) begin
         bad++; $display("[TB] FAIL full_third: accepted=%0d ready=%b expected 2/0", acceptedCount, readyAtDone);
      end
   endtask

   task automatic test_reset_midstream();
      bit seen = 0;
      @(posedge clk); #1;
      start = 1'b1; start_addr = 8'h10;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         applyStimulus(mk(4'd0, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b0));
         @(posedge clk); #1;
         if (mem_we) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++; $display("[TB] FAIL midreset_wait: mem_we=0 expected a write within 20 cycles");
      end
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if (outVec() !== 55'd0) begin
         bad++; $display("[TB] FAIL midreset_outputs: got %h expected 0", outVec());
      end
      rst = 1'b0; in_valid = 1'b0;
      stim.delete();
      stim.push_back(mk(4'd0, 5'd1, 5'd2, 5'd3, 16'($urandom), 1'b0));
      stim.push_back(mk(4'd1, 5'd1, 5'd2, 5'd3, 16'($urandom), 1'b1));
      runSession(8'h40, 0, 0);
      total++;
      if (timedOut || gotData.size() != 2 || gotAddr[0] !== 8'h40 || gotAddr[1] !== 8'h41 ||
          gotData[0] !== 32'h00221820 || gotData[1] !== 32'h00221822 || wcAtDone != 2) begin
         bad++; $display("[TB] FAIL midreset_restart: n=%0d wc=%0d expected 2 writes at 40,41", gotData.size(), wcAtDone);
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 25; s++) begin
         logic [7:0] sa;
         int len;
         sa = ($urandom_range(1) == 0) ? 8'(8'hF8 + $urandom_range(7)) : 8'($urandom);
         len = $urandom_range(6, 1);
         stim.delete();
         for (int i = 0; i < len; i++)
            stim.push_back(mk(4'($urandom_range(11)), 5'($urandom), 5'($urandom), 5'($urandom),
                              16'($urandom), 1'(i == len - 1)));
         modelSession(sa);
         runSession(sa, 1, 1);
         total++;
         if (timedOut || gotData.size() != expData.size()) begin
            bad++; $display("[TB] FAIL rand%0d_count: writes=%0d expected %0d", s, gotData.size(), expData.size());
         end
         for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
            total++;
            if (gotAddr[i] !== expAddr[i] || gotData[i] !== expData[i]) begin
               bad++; $display("[TB] FAIL rand%0d_word%0d: got %h/%h expected %h/%h", s, i,
                               gotAddr[i], gotData[i], expAddr[i], expData[i]);
            end
         end
         total++;
         if (acceptedCount != expAcc || wcAtDone != expWc || illAtDone !== expIll || fullAtDone !== expFull) begin
            bad++; $display("[TB] FAIL rand%0d_status: acc=%0d wc=%0d ill=%b full=%b expected %0d/%0d/%b/%b", s,
                            acceptedCount, wcAtDone, illAtDone, fullAtDone, expAcc, expWc, expIll, expFull);
         end
         total++;
         if (doneCount != 1 || busyAfterDone !== 1'b0) begin
            bad++; $display("[TB] FAIL rand%0d_end: done=%0d busyAfter=%b expected 1/0", s, doneCount, busyAfterDone);
         end
      end
   endtask

`ifdef LOADER_READBACK_EN
   task automatic test_readback();
      stim.delete();
      stim.push_back(mk(4'd0, 5'd1, 5'd2, 5'd3, 16'($urandom), 1'b0));
      stim.push_back(mk(4'd4, 5'd2, 5'd3, 5'($urandom), 16'h1234, 1'b0));
      stim.push_back(mk(4'd1, 5'd7, 5'd8, 5'd9, 16'($urandom), 1'b0));
      stim.push_back(mk(4'd3, 5'd4, 5'd5, 5'd6, 16'($urandom), 1'b1));
      runSession(8'h00, 0, 0);
      total++;
      if (timedOut || gotData.size() != 4 || verifyAtDone !== 1'b1) begin
         bad++; $display("[TB] FAIL readback_verify: writes=%0d err_verify=%b expected 4/1", gotData.size(), verifyAtDone);
      end
      for (int i = 1; i < 4; i++) begin
         total++;
         if (gotCycle.size() <= i || gotCycle[i] - gotCycle[i-1] != 3) begin
            bad++; $display("[TB] FAIL readback_spacing%0d: write spacing not 3 cycles", i);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_add();
      test_back_to_back();
      test_illegal();
      test_full();
      test_reset_midstream();
      test_random();
`ifdef LOADER_READBACK_EN
      test_readback();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
